// File: rtl/fp_mul_sched.sv
// fp_mul_sched
// Round-robin scheduler that shares one floating-point multiply core among
// N_REQ requesters. Each requester may have at most one operation outstanding.
// A granted request is registered into the core operand outputs. A tag
// {valid, id, err} then travels down a MUL_LAT+1 deep shift register alongside
// the core pipeline. When the tag comes out of the last stage, the core result
// is latched into that requester's response slot.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   en                 1 = grants allowed, 0 = stop granting and drain in-flight ops
//   idle               scheduler is in IDLE (nothing in flight, nothing granted)
//   req_valid/ready    per-requester request handshake (ready is a one-hot grant)
//   req_x/req_y        per-requester 32-bit operands, slice i = [32*i +: 32]
//   req_rmode          per-requester 3-bit rounding mode, slice i = [3*i +: 3]
//   rsp_valid/ready    per-requester response handshake
//   rsp_z              per-requester 32-bit result
//   rsp_flags          per-requester {err, ovrf, udrf}
//   mul_fp_X/Y/r_mode  registered operands to the multiply core
//   mul_fp_Z/ovrf/udrf core result, valid MUL_LAT cycles after the operands

module fp_mul_sched #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 idle,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_x,
  input  logic [32*N_REQ-1:0]  req_y,
  input  logic [3*N_REQ-1:0]   req_rmode,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [32*N_REQ-1:0]  rsp_z,
  output logic [3*N_REQ-1:0]   rsp_flags,
  output logic [31:0]          mul_fp_X,
  output logic [31:0]          mul_fp_Y,
  output logic [2:0]           mul_r_mode,
  input  logic [31:0]          mul_fp_Z,
  input  logic                 mul_ovrf,
  input  logic                 mul_udrf
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int DEPTH = MUL_LAT + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [N_REQ-1:0] pend;

  // Tag pipeline that runs in step with the core pipeline.
  logic [DEPTH-1:0] tag_v;
  logic [DEPTH-1:0] tag_err;
  logic [ID_W-1:0]  tag_id [DEPTH];

  // Response slots, one per requester.
  logic [31:0] z_q     [N_REQ];
  logic [2:0]  flags_q [N_REQ];

  // Per-requester views of the packed operand buses.
  logic [31:0] x_arr  [N_REQ];
  logic [31:0] y_arr  [N_REQ];
  logic [2:0]  rm_arr [N_REQ];

  logic            found;
  logic            grant;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] win_next;
  logic [2:0]      sel_rm;
  logic            sel_err;
  logic [2:0]      fwd_rm;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      x_arr[i]  = req_x[32*i +: 32];
      y_arr[i]  = req_y[32*i +: 32];
      rm_arr[i] = req_rmode[3*i +: 3];
    end
  end

  // The winner is the first eligible requester at or after rr_ptr, wrapping
  // around. A requester is eligible when it is valid and has nothing pending.
  always_comb begin : pick_winner
    int idx;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand] && !pend[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  assign grant    = found && (state == ST_ACTIVE);
  assign win_next = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;

  // Rounding modes above RMM are illegal. They are sent to the core as RNE,
  // and the substitution is reported back through the err flag.
  assign sel_rm  = rm_arr[win_id];
  assign sel_err = (sel_rm > 3'b100);
  assign fwd_rm  = sel_err ? 3'b000 : sel_rm;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_z[32*i +: 32]    = z_q[i];
      rsp_flags[3*i +: 3]  = flags_q[i];
    end
  end

  assign idle = (state == ST_IDLE);

  // Consume, grant and capture never target the same slot on the same edge.
  // A slot with rsp_valid set is still pending, so it cannot be granted.
  // It also has no tag in flight, so it cannot be captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      pend       <= '0;
      rsp_valid  <= '0;
      mul_fp_X   <= '0;
      mul_fp_Y   <= '0;
      mul_r_mode <= '0;
      tag_v      <= '0;
      tag_err    <= '0;
      for (int k = 0; k < DEPTH; k++) tag_id[k] <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        z_q[i]     <= '0;
        flags_q[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE:   if (en) state <= ST_ACTIVE;
        ST_ACTIVE: if (!en) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (en)              state <= ST_ACTIVE;
          else if (pend == '0) state <= ST_IDLE;
        end
        default:   state <= ST_IDLE;
      endcase

      for (int i = 0; i < N_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
          pend[i]      <= 1'b0;
        end
      end

      if (grant) begin
        pend[win_id] <= 1'b1;
        rr_ptr       <= win_next;
        mul_fp_X     <= x_arr[win_id];
        mul_fp_Y     <= y_arr[win_id];
        mul_r_mode   <= fwd_rm;
      end

      tag_v[0]   <= grant;
      tag_id[0]  <= win_id;
      tag_err[0] <= grant && sel_err;
      for (int k = 1; k < DEPTH; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_id[k]  <= tag_id[k-1];
        tag_err[k] <= tag_err[k-1];
      end

      if (tag_v[DEPTH-1]) begin
        z_q[tag_id[DEPTH-1]]       <= mul_fp_Z;
        flags_q[tag_id[DEPTH-1]]   <= {tag_err[DEPTH-1], mul_ovrf, mul_udrf};
        rsp_valid[tag_id[DEPTH-1]] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_sched.sv
// tb_fp_mul_sched
// Directed bench for fp_mul_sched. It uses two instances.
// Instance a has a combinational core (MUL_LAT=0).
// Instance b has a three-stage core (MUL_LAT=3).
// The multiply core is modelled by a lookup of hand-computed IEEE-754 products
// for the operand pairs used below.

module tb_fp_mul_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         en_a, idle_a;
  logic [3:0]   req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a;
  logic [127:0] req_x_a, req_y_a, rsp_z_a;
  logic [11:0]  req_rmode_a, rsp_flags_a;
  logic [31:0]  mul_x_a, mul_y_a, mul_z_a;
  logic [2:0]   mul_rm_a;
  logic         mul_ovrf_a, mul_udrf_a;

  logic         en_b, idle_b;
  logic [3:0]   req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  logic [127:0] req_x_b, req_y_b, rsp_z_b;
  logic [11:0]  req_rmode_b, rsp_flags_b;
  logic [31:0]  mul_x_b, mul_y_b, mul_z_b;
  logic [2:0]   mul_rm_b;
  logic         mul_ovrf_b, mul_udrf_b;

  int total = 0;
  int bad   = 0;

  fp_mul_sched #(.N_REQ(4), .MUL_LAT(0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .idle(idle_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_x(req_x_a), .req_y(req_y_a), .req_rmode(req_rmode_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_z(rsp_z_a), .rsp_flags(rsp_flags_a),
    .mul_fp_X(mul_x_a), .mul_fp_Y(mul_y_a), .mul_r_mode(mul_rm_a),
    .mul_fp_Z(mul_z_a), .mul_ovrf(mul_ovrf_a), .mul_udrf(mul_udrf_a)
  );

  fp_mul_sched #(.N_REQ(4), .MUL_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .idle(idle_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_x(req_x_b), .req_y(req_y_b), .req_rmode(req_rmode_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_z(rsp_z_b), .rsp_flags(rsp_flags_b),
    .mul_fp_X(mul_x_b), .mul_fp_Y(mul_y_b), .mul_r_mode(mul_rm_b),
    .mul_fp_Z(mul_z_b), .mul_ovrf(mul_ovrf_b), .mul_udrf(mul_udrf_b)
  );

  // Returns {ovrf, udrf, z} for the operand pairs used in this bench.
  function automatic logic [33:0] core_fn(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h40400000, 32'h40400000}: return {2'b00, 32'h41100000};
      {32'h3f800000, 32'h40000000}: return {2'b00, 32'h40000000};
      {32'h3fc00000, 32'h40000000}: return {2'b00, 32'h40400000};
      {32'h7f000000, 32'h7f000000}: return {2'b10, 32'h7f800000};
      {32'h00800000, 32'h00800000}: return {2'b01, 32'h00000000};
      {32'h40000000, 32'h40400000}: return {2'b00, 32'h40c00000};
      {32'h40800000, 32'h40000000}: return {2'b00, 32'h41000000};
      default:                      return {2'b00, 32'h7fc00000};
    endcase
  endfunction

  // Core for instance a is combinational.
  always_comb {mul_ovrf_a, mul_udrf_a, mul_z_a} = core_fn(mul_x_a, mul_y_a);

  // Core for instance b has three register stages.
  logic [33:0] pipe1, pipe2, pipe3;
  always @(posedge clk) begin
    pipe1 <= core_fn(mul_x_b, mul_y_b);
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end
  assign {mul_ovrf_b, mul_udrf_b, mul_z_b} = pipe3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [31:0] x, input logic [31:0] y,
                               input logic [2:0] rm);
    req_x_a[32*i +: 32]    = x;
    req_y_a[32*i +: 32]    = y;
    req_rmode_a[3*i +: 3]  = rm;
  endtask

  logic [3:0] exp_rdy, exp_v;
  logic [3:0] hold_seq [8];

  initial begin
    rst = 1'b1;
    en_a = 1'b0; req_valid_a = '0; rsp_ready_a = '0;
    req_x_a = '0; req_y_a = '0; req_rmode_a = '0;
    en_b = 1'b0; req_valid_b = '0; rsp_ready_b = '0;
    req_x_b = '0; req_y_b = '0; req_rmode_b = '0;
    tick();
    tick();

    // Reset state.
    checkOutput("rst_idle",      idle_a, 1'b1);
    checkOutput("rst_ready",     req_ready_a, 4'b0000);
    checkOutput("rst_rsp_valid", rsp_valid_a, 4'b0000);
    checkOutput("rst_mul_x",     mul_x_a, 32'h0);
    checkOutput("rst_mul_rm",    mul_rm_a, 3'b000);
    checkOutput("rst_rsp_z",     rsp_z_a, 128'h0);

    // Single RTZ multiply on requester 0, two-cycle latency.
    rst = 1'b0;
    en_a = 1'b1;
    applyStimulus(0, 32'h40400000, 32'h40400000, 3'b001);
    req_valid_a = 4'b0001;
    #1;
    checkOutput("idle_no_grant", req_ready_a, 4'b0000);
    tick();
    checkOutput("grant_req0", req_ready_a, 4'b0001);
    checkOutput("active_not_idle", idle_a, 1'b0);
    tick();
    req_valid_a = 4'b0000;
    checkOutput("mul_rm_rtz", mul_rm_a, 3'b001);
    checkOutput("mul_x_req0", mul_x_a, 32'h40400000);
    checkOutput("rsp_not_yet", rsp_valid_a, 4'b0000);
    tick();
    checkOutput("rsp0_valid", rsp_valid_a, 4'b0001);
    checkOutput("rsp0_z", rsp_z_a[31:0], 32'h41100000);
    checkOutput("rsp0_flags", rsp_flags_a[2:0], 3'b000);
    tick();
    checkOutput("rsp0_hold", rsp_valid_a, 4'b0001);
    checkOutput("rsp0_hold_z", rsp_z_a[31:0], 32'h41100000);
    rsp_ready_a = 4'b0001;
    tick();
    rsp_ready_a = 4'b0000;
    checkOutput("rsp0_consumed", rsp_valid_a, 4'b0000);

    // An illegal rounding mode goes out as RNE and is flagged with err.
    applyStimulus(1, 32'h3f800000, 32'h40000000, 3'b101);
    req_valid_a = 4'b0010;
    #1;
    checkOutput("grant_req1", req_ready_a, 4'b0010);
    tick();
    req_valid_a = 4'b0000;
    checkOutput("mul_rm_forced", mul_rm_a, 3'b000);
    checkOutput("mul_x_req1", mul_x_a, 32'h3f800000);
    tick();
    checkOutput("rsp1_valid", rsp_valid_a, 4'b0010);
    checkOutput("rsp1_z", rsp_z_a[63:32], 32'h40000000);
    checkOutput("rsp1_flags", rsp_flags_a[5:3], 3'b100);
    rsp_ready_a = 4'b0010;
    tick();
    rsp_ready_a = 4'b0000;

    // All requesters are valid. rr_ptr is 2 here, so the grant order is
    // 2,3,0,1,... and each response appears two cycles after its grant.
    for (int i = 0; i < 4; i++) applyStimulus(i, 32'h3fc00000, 32'h40000000, 3'b000);
    req_valid_a = 4'b1111;
    rsp_ready_a = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid_a = 4'b0000;
      #1;
      exp_rdy = (k < 8) ? (4'b0001 << ((2 + k) % 4)) : 4'b0000;
      exp_v   = (k >= 2) ? (4'b0001 << (k % 4)) : 4'b0000;
      checkOutput("rr_grant", req_ready_a, exp_rdy);
      checkOutput("rr_rsp", rsp_valid_a, exp_v);
      if (k == 4) checkOutput("rr_rsp0_z", rsp_z_a[31:0], 32'h40400000);
      tick();
    end

    // Requester 2 holds its result, so the others keep being served.
    // It is re-granted only on the cycle after its consume.
    hold_seq = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    req_valid_a = 4'b1111;
    rsp_ready_a = 4'b1011;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) rsp_ready_a = 4'b1111;
      #1;
      checkOutput("hold_grant", req_ready_a, hold_seq[k]);
      if (k == 5) begin
        checkOutput("hold_rsp2_valid", rsp_valid_a[2], 1'b1);
        checkOutput("hold_rsp2_z", rsp_z_a[95:64], 32'h40400000);
      end
      tick();
    end
    req_valid_a = 4'b0000;
    repeat (4) tick();
    checkOutput("hold_drained", rsp_valid_a, 4'b0000);
    rsp_ready_a = 4'b0000;

    // Overflow op, then en drops: DRAIN, no grants, IDLE after the consume.
    applyStimulus(3, 32'h7f000000, 32'h7f000000, 3'b000);
    req_valid_a = 4'b1000;
    #1;
    checkOutput("grant_req3", req_ready_a, 4'b1000);
    tick();
    req_valid_a = 4'b0000;
    en_a = 1'b0;
    tick();
    checkOutput("drain_not_idle", idle_a, 1'b0);
    checkOutput("drain_rsp3_valid", rsp_valid_a, 4'b1000);
    checkOutput("drain_rsp3_z", rsp_z_a[127:96], 32'h7f800000);
    checkOutput("drain_rsp3_flags", rsp_flags_a[11:9], 3'b010);
    req_valid_a = 4'b0001;
    #1;
    checkOutput("drain_no_grant", req_ready_a, 4'b0000);
    rsp_ready_a = 4'b1000;
    tick();
    rsp_ready_a = 4'b0000;
    checkOutput("drain_still", idle_a, 1'b0);
    checkOutput("drain_consumed", rsp_valid_a, 4'b0000);
    tick();
    checkOutput("drain_to_idle", idle_a, 1'b1);
    req_valid_a = 4'b0000;

    // Reset with ops in flight drops everything.
    en_a = 1'b1;
    tick();
    applyStimulus(0, 32'h00800000, 32'h00800000, 3'b000);
    applyStimulus(1, 32'h40800000, 32'h40000000, 3'b000);
    req_valid_a = 4'b0011;
    #1;
    checkOutput("pre_rst_grant0", req_ready_a, 4'b0001);
    tick();
    checkOutput("pre_rst_grant1", req_ready_a, 4'b0010);
    tick();
    req_valid_a = 4'b0000;
    checkOutput("udrf_valid", rsp_valid_a, 4'b0001);
    checkOutput("udrf_z", rsp_z_a[31:0], 32'h00000000);
    checkOutput("udrf_flags", rsp_flags_a[2:0], 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_a = 1'b0;
    checkOutput("midrst_rsp_valid", rsp_valid_a, 4'b0000);
    checkOutput("midrst_idle", idle_a, 1'b1);
    checkOutput("midrst_ready", req_ready_a, 4'b0000);
    checkOutput("midrst_mul_x", mul_x_a, 32'h0);
    tick();
    tick();
    checkOutput("no_late_rsp", rsp_valid_a, 4'b0000);

    // Pipelined core: back-to-back grants give results at T+5 and T+6.
    en_b = 1'b1;
    tick();
    req_x_b[31:0]  = 32'h40000000; req_y_b[31:0]  = 32'h40400000;
    req_x_b[63:32] = 32'h40800000; req_y_b[63:32] = 32'h40000000;
    req_valid_b = 4'b0011;
    #1;
    checkOutput("lat3_grant0", req_ready_b, 4'b0001);
    tick();
    checkOutput("lat3_grant1", req_ready_b, 4'b0010);
    tick();
    req_valid_b = 4'b0000;
    for (int k = 2; k <= 6; k++) begin
      exp_v = (k == 5) ? 4'b0001 : ((k == 6) ? 4'b0011 : 4'b0000);
      checkOutput("lat3_rsp_valid", rsp_valid_b, exp_v);
      if (k == 5) checkOutput("lat3_rsp0_z", rsp_z_b[31:0], 32'h40c00000);
      if (k == 6) begin
        checkOutput("lat3_rsp1_z", rsp_z_b[63:32], 32'h41000000);
        checkOutput("lat3_flags", rsp_flags_b[5:0], 6'b000000);
      end
      if (k < 6) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
